arm_seq_ctrl: RTL
=================

# arm_seq_ctrl

Multi-cycle instruction sequencer for the ARMcpu2 core. It fetches from the instruction port of the dual-port RAM and decodes the data-processing and LDR/STR subset. For each instruction it steps the register file, ALU and data RAM through fixed phases, replacing combinational control with a clocked FSM. It owns the PC and produces every enable and address the datapath needs.

## Interface
- Parameters:
- `PC_W`, 8: PC/RAM word-address width; PC wraps modulo 2^PC_W
- Ports:
- `clk` in 1: sole clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `run` in 1: start/continue execution
- `instr` in 32: RAM port-B read data, valid one cycle after `pc` is presented
- `rf_q_a`, `rf_q_b`, `rf_q_c` in 32 each: register-file read data (combinational w.r.t. addresses)
- `alu_result` in 32: ALU output (combinational)
- `ram_rdata` in 32: RAM port-A read data, valid one cycle after `ram_addr`
- `pc` out PC_W: instruction fetch address
- `rf_addr_a`, `rf_addr_b`, `rf_addr_c` out 4 each: Rn, Rm, Rd selects
- `rf_wdata` out 32, `rf_we` out 1: writeback on port C
- `alu_op` out 4, `alu_a` out 32, `alu_b` out 32: ALU controls/operands
- `ram_addr` out PC_W, `ram_wdata` out 32, `ram_we` out 1: data port A
- `busy` out 1: high in any state other than IDLE/HALT
- `illegal` out 1: sticky, set on an undecodable instruction

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: wait for `run`=1, then go to FETCH.
- FETCH: `pc` is stable; go to DECODE.
- DECODE: capture `instr` into IR, drive `rf_addr_a`=IR[19:16], `rf_addr_b`=IR[3:0], `rf_addr_c`=IR[15:12]; classify.
- Condition field IR[31:28] ignored.
- DP: IR[27:26]=00. `alu_op`=IR[24:21], `alu_a`=Rn. `alu_b`=zero-extended IR[7:0] if I=1, else Rm.
- LDR: op=01, I=0, P=1, U=1, B=0, W=0, L=1. `alu_op`=0100 (add), `alu_b`=zero-extended IR[11:0].
- STR: op=01, I=1, P=1, U=1, B=0, W=0, L=0. `alu_op`=0100, `alu_b`=Rm.
- Anything else: set `illegal`, go to HALT; no writes.
- EXEC: register `alu_a`/`alu_b`/`alu_op`; next cycle capture `alu_result` into a result register. DP goes to WB; LDR/STR go to MEM.
- MEM:
  - `ram_addr`=result[PC_W-1:0].
  - STR: `ram_wdata`=`rf_q_c` (Rd), one-cycle `ram_we` pulse; instruction complete.
  - LDR: read issued; go to WB.
- WB:
  - `rf_wdata`=result for DP, or `ram_rdata` for LDR; `rf_we` high exactly one cycle.
  - DP opcodes 1000–1011 (TST/TEQ/CMP/CMN) skip the write.
  - Rd=15: no RF write; load `pc` with wdata[PC_W-1:0] (branch).
- Completion: `pc` increments by 1 unless branched. Next state is FETCH if `run`=1, else IDLE.
- HALT: only reset exits.

## Timing
- Reset: state IDLE; `pc`, IR, all address/data outputs, `rf_we`, `ram_we`, `busy`, `illegal` are 0.
- Latency from entering FETCH:
  - DP: 4 cycles (FETCH, DECODE, EXEC, WB)
  - STR: 4 cycles (FETCH, DECODE, EXEC, MEM)
  - LDR: 5 cycles
- `rf_we`/`ram_we` are never high in the same cycle and are never high outside WB/MEM.
- `run` is sampled only in IDLE and at instruction completion. Deassertion mid-instruction finishes the current instruction.
- PC wrap: 2^PC_W-1 increments to 0.
- Reset asserted mid-instruction: immediate return to reset values; pending writes are dropped.
- Back-to-back instructions: FETCH follows the completing state with no bubble.

## Structure
- Package `arm_ctrl_pkg`:
  - state enum
  - op-field constants (OP_DP=00, OP_MEM=01)
  - `ALU_ADD`=4'b0100
  - compare-opcode range 1000–1011
  - instruction-class enum (DP_IMM, DP_REG, LDR_IMM, STR_REG, ILLEGAL)
- Sub-module `arm_instr_decode`: combinational IR → class and field extraction; the FSM stays in `arm_seq_ctrl`.

## Test plan
- DP immediate. Stimulus: ADD (`alu_op`=0100), I=1, Rn=R1 (=5), imm8=7, Rd=R2. Required: `rf_we` in cycle 4 with `rf_addr_c`=2 and `rf_wdata`=12; `pc` 0→1.
- LDR. Stimulus: Rn=R3 (=0x10), imm12=4, Rd=R4, RAM[0x14]=0xDEADBEEF. Required: `ram_addr`=0x14 in MEM; `rf_we` in cycle 5 with `rf_wdata`=0xDEADBEEF.
- STR. Stimulus: Rn=R1 (=0x20), Rm=R2 (=3), Rd=R5 (=0xA5). Required: single `ram_we` pulse with `ram_addr`=0x23 and `ram_wdata`=0xA5; `rf_we` stays 0.
- CMP and branch. Stimulus: CMP (opcode 1010), then ADD with Rd=15 giving result 0x40. Required: CMP produces no `rf_we`; after the ADD, `pc`=0x40 with no RF write.
- Illegal, wrap and reset:
  - Stimulus: op=10 instruction. Required: `illegal`=1, HALT, `busy`=0, and it persists with `run`=1.
  - Stimulus: `pc`=0xFF, then a DP instruction. Required: `pc`=0x00.
  - Stimulus: `rst_n` low during MEM of STR. Required: no `ram_we`; all outputs 0.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and constants for the ARMcpu2 multi-cycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        DP_IMM,
        DP_REG,
        LDR_IMM,
        STR_REG,
        ILLEGAL
    } iclass_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;

    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] CMP_OP_LO = 4'b1000;
    localparam logic [3:0] CMP_OP_HI = 4'b1011;

    // {I,P,U,B,W,L} for the only two memory forms the core accepts
    localparam logic [5:0] LDR_FLAGS = 6'b011001;
    localparam logic [5:0] STR_FLAGS = 6'b111000;

    typedef struct packed {
        iclass_t     iclass;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rd;
        logic [3:0]  alu_op;
        logic        use_imm;
        logic [31:0] imm;
        logic        writes_rd;
    } dec_t;

    function automatic logic is_cmp(input logic [3:0] op);
        return (op >= CMP_OP_LO) && (op <= CMP_OP_HI);
    endfunction

endpackage

// File: rtl/arm_instr_decode.sv
// Classifies an instruction word and extracts register selects, ALU opcode and immediate.
// Latency: purely combinational.
// Backpressure: none.
module arm_instr_decode
    import arm_ctrl_pkg::*;
(
    input  logic [27:0] ir,
    output dec_t        dec
);

    always_comb begin
        dec           = '0;
        dec.iclass    = ILLEGAL;
        dec.rn        = ir[19:16];
        dec.rm        = ir[3:0];
        dec.rd        = ir[15:12];
        dec.alu_op    = ALU_ADD;
        if (ir[27:26] == OP_DP) begin
            dec.iclass    = ir[25] ? DP_IMM : DP_REG;
            dec.alu_op    = ir[24:21];
            dec.use_imm   = ir[25];
            dec.imm       = {24'd0, ir[7:0]};
            dec.writes_rd = !is_cmp(ir[24:21]);
        end else if (ir[27:26] == OP_MEM && ir[25:20] == LDR_FLAGS) begin
            dec.iclass    = LDR_IMM;
            dec.use_imm   = 1'b1;
            dec.imm       = {20'd0, ir[11:0]};
            dec.writes_rd = 1'b1;
        end else if (ir[27:26] == OP_MEM && ir[25:20] == STR_FLAGS) begin
            dec.iclass    = STR_REG;
        end
    end

endmodule

// File: rtl/arm_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer driving the ARMcpu2 datapath.
// Latency: DP 4 cycles, STR 4 cycles, LDR 5 cycles from FETCH; no bubble between instructions.
// Backpressure: none; run is sampled only in IDLE and at instruction completion.
module arm_seq_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [31:0]     instr,
    input  logic [31:0]     rf_q_a,
    input  logic [31:0]     rf_q_b,
    input  logic [31:0]     rf_q_c,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     ram_rdata,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      rf_addr_a,
    output logic [3:0]      rf_addr_b,
    output logic [3:0]      rf_addr_c,
    output logic [31:0]     rf_wdata,
    output logic            rf_we,
    output logic [3:0]      alu_op,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [PC_W-1:0] ram_addr,
    output logic [31:0]     ram_wdata,
    output logic            ram_we,
    output logic            busy,
    output logic            illegal
);

    state_t      state;
    logic [27:0] ir;
    logic [31:0] result;
    logic [27:0] dec_src;
    dec_t        dec;
    logic        is_dp;
    logic [31:0] wb_data;
    logic        wb_branch;
    logic        unused_cond;

    // The condition field is ignored; every instruction executes unconditionally.
    assign unused_cond = ^instr[31:28];

    // In DECODE the word is still on the RAM port; afterwards IR holds it.
    assign dec_src = (state == S_DECODE) ? instr[27:0] : ir;

    arm_instr_decode u_decode (
        .ir  (dec_src),
        .dec (dec)
    );

    assign is_dp     = (dec.iclass == DP_IMM) || (dec.iclass == DP_REG);
    assign wb_data   = (dec.iclass == LDR_IMM) ? ram_rdata : result;
    assign wb_branch = dec.writes_rd && (dec.rd == 4'hF);

    // RF and ALU are combinational, so operands are only presented during EXEC
    assign alu_a    = (state == S_EXEC) ? rf_q_a : 32'd0;
    assign alu_b    = (state == S_EXEC) ? (dec.use_imm ? dec.imm : rf_q_b) : 32'd0;
    assign rf_wdata = (state == S_WB) ? wb_data : 32'd0;
    assign busy     = (state != S_IDLE) && (state != S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            result    <= '0;
            rf_addr_a <= '0;
            rf_addr_b <= '0;
            rf_addr_c <= '0;
            rf_we     <= 1'b0;
            alu_op    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir        <= instr[27:0];
                    rf_addr_a <= dec.rn;
                    rf_addr_b <= dec.rm;
                    rf_addr_c <= dec.rd;
                    alu_op    <= dec.alu_op;
                    if (dec.iclass == ILLEGAL) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result <= alu_result;
                    if (is_dp) begin
                        rf_we <= dec.writes_rd && (dec.rd != 4'hF);
                        state <= S_WB;
                    end else begin
                        ram_addr <= alu_result[PC_W-1:0];
                        if (dec.iclass == STR_REG) begin
                            ram_wdata <= rf_q_c;
                            ram_we    <= 1'b1;
                        end
                        state <= S_MEM;
                    end
                end
                S_MEM: begin
                    ram_we <= 1'b0;
                    if (dec.iclass == STR_REG) begin
                        pc    <= pc + PC_W'(1);
                        state <= run ? S_FETCH : S_IDLE;
                    end else begin
                        rf_we <= (dec.rd != 4'hF);
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    rf_we <= 1'b0;
                    pc    <= wb_branch ? wb_data[PC_W-1:0] : pc + PC_W'(1);
                    state <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
